instr_encoder: RTL and testbench
================================

# instr_encoder

Inverse of the pipeline's immediate extender: packs an immediate value plus register, funct3 and opcode fields into a 32-bit RV32I instruction word. Each word is tagged with a word address.
- Sits in the boot/self-test path: a sequencer hands in field tuples, and encoded words drain into instruction-memory write logic.
- Range-checks every immediate and rejects values that cannot be encoded.
- Buffers up to two encoded words behind a valid/ready handshake.

## Interface
- ADDR_W, 10: width of the word-address counter.
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request can be accepted (count != 2).
- in_immsrc  in  3  format, same codes as the extender: 000 I, 001 S, 010 B, 011 J, 100 U; 101–111 invalid.
- in_imm  in  32  immediate value, in the form the extender produces.
- in_opcode  in  7  opcode field.
- in_rd / in_rs1 / in_rs2  in  5 each  register fields.
- in_funct3  in  3  funct3 field.
- addr_load  in  1  reload address counter.
- addr_base  in  ADDR_W  value loaded on addr_load.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer takes head.
- out_instr  out  32  encoded word at head.
- out_addr  out  ADDR_W  address tagged on head.
- err  out  1  one-cycle pulse: the previous accepted request was rejected.
- err_code  out  2  01 bad immsrc, 10 immediate out of range, 11 misaligned (B/J with imm[0]=1); holds last value.

## Operation
- Accept occurs when in_valid && in_ready at a rising edge.
- Encoding, computed combinationally from the inputs and written into the FIFO at accept:
  - I: [31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [6:0]=opcode. Legal iff imm[31:11] all equal.
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0]. Legal iff imm[31:11] all equal.
  - B: [31]=imm[12], [30:25]=imm[10:5], rs2/rs1/funct3 as S, [11:8]=imm[4:1], [7]=imm[11]. Legal iff imm[31:12] all equal and imm[0]=0.
  - U: [31:12]=imm[19:0], [11:7]=rd. The imm is unshifted, matching the extender's U output. Legal iff imm[31:19] all equal.
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd. Legal iff imm[31:20] all equal and imm[0]=0.
  - [6:0]=opcode in every format. Fields unused by a format are ignored.
- Error check priority: bad immsrc, then range, then alignment.
- A rejected request still completes the handshake. Rejection effects:
  - Nothing is written to the FIFO.
  - The address counter is not advanced.
  - err pulses high in the cycle after accept, and err_code updates.
- Address counter wr_addr, ADDR_W bits:
  - A good accept tags the word with the current wr_addr, then wr_addr increments, wrapping modulo 2^ADDR_W.
  - When addr_load is high, wr_addr <= addr_base. A good accept in the same cycle uses the old wr_addr; load wins over increment.
- FIFO: 2 entries of {instr, addr}, with count 0..2.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop when count=1 leaves count=1 and keeps order.
  - When count=2, in_ready=0; a pop that cycle frees space for the next cycle only.
  - No combinational path from out_ready to in_ready.

## Timing
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_addr=0, err=0, err_code=00, wr_addr=0, count=0.
- Latency: accept at edge N gives out_valid=1 after edge N, with word visible in that cycle (1 cycle) when FIFO was empty.
- Throughput: 1 word/cycle sustained while out_ready=1.
- out_instr and out_addr hold stable while out_valid && !out_ready.
- Reset asserted mid-stream flushes the FIFO and drops any pending err pulse in the same edge.

## Structure
- Shared package holds:
  - IMM_I/S/B/J/U 3-bit constants, shared with the extender.
  - ERR_* codes.
  - Field bit-position localparams.
- Sub-module imm_pack (combinational): takes immsrc, imm and fields; returns instr and err_code. The top holds the address counter, FIFO and err register.

## Test plan
- I-type, imm=0xFFFFF800 (-2048), rs1=1, rd=2, funct3=0, opcode=0x13 → out_instr=0x80008113, out_addr=0, err=0; word appears 1 cycle after accept.
- J-type, imm=0x00000010, rd=1, opcode=0x6F → 0x010000EF. B-type imm=0x00000011 → err=1, err_code=11, no word, wr_addr unchanged.
- U-type, imm=0x00000015, rd=7, opcode=0x37 → 0x000153B7. I-type imm=0x00000800 → err_code=10.
- Backpressure: out_ready=0 with 3 back-to-back good requests → in_ready drops after the 2nd, head held stable. Releasing out_ready drains in order with addrs 0,1,2.
- addr_load with addr_base=0x3FF together with a good accept → that word gets addr 0. Next two words get 0x3FF, then 0x000 (wrap).
- reset_n=0 for one cycle while FIFO is full → out_valid=0 and in_ready=1 after the edge; immsrc=101 afterwards → err_code=01.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: immediate format codes,
// error codes and RV32I field positions.
package instr_encoder_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_IMMSRC = 2'b01,
    ERR_RANGE  = 2'b10,
    ERR_ALIGN  = 2'b11
  } err_code_t;

  localparam int OPCODE_LSB   = 0;
  localparam int RD_LSB       = 7;
  localparam int FUNCT3_LSB   = 12;
  localparam int RS1_LSB      = 15;
  localparam int RS2_LSB      = 20;
  localparam int IMM_I_LSB    = 20;
  localparam int IMM_S_LO_LSB = 7;
  localparam int IMM_S_HI_LSB = 25;
  localparam int IMM_U_LSB    = 12;

  // True when imm[31:msb] are all copies of one bit, i.e. the value is a
  // sign-extension of its low msb+1 bits.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned msb);
    logic [31:0] s;
    s = $signed(imm) >>> msb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle between the field sequencer, the encoder and the
// instruction-memory write logic.
interface instr_encoder_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_immsrc;
  logic [31:0]       in_imm;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_immsrc, in_imm, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
    input  in_ready,
    input  out_valid, out_instr, out_addr,
    output out_ready
  );

  modport slave (
    input  in_valid, in_immsrc, in_imm, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
    output in_ready,
    output out_valid, out_instr, out_addr,
    input  out_ready
  );
endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: scatters the immediate and register fields into an
// RV32I word and classifies the request as legal or rejected.
module instr_encoder_imm_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  immsrc,
  input  logic [31:0] imm,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  output logic [31:0] instr,
  output err_code_t   err_code
);

  // Range is checked before alignment so an odd, out-of-range offset reports range.
  always_comb begin
    instr    = '0;
    err_code = ERR_NONE;
    instr[OPCODE_LSB +: 7] = opcode;
    case (immsrc)
      IMM_I: begin
        instr[RD_LSB +: 5]     = rd;
        instr[FUNCT3_LSB +: 3] = funct3;
        instr[RS1_LSB +: 5]    = rs1;
        instr[IMM_I_LSB +: 12] = imm[11:0];
        if (!imm_fits(imm, 11)) err_code = ERR_RANGE;
      end
      IMM_S: begin
        instr[IMM_S_LO_LSB +: 5] = imm[4:0];
        instr[FUNCT3_LSB +: 3]   = funct3;
        instr[RS1_LSB +: 5]      = rs1;
        instr[RS2_LSB +: 5]      = rs2;
        instr[IMM_S_HI_LSB +: 7] = imm[11:5];
        if (!imm_fits(imm, 11)) err_code = ERR_RANGE;
      end
      IMM_B: begin
        instr[7]               = imm[11];
        instr[11:8]            = imm[4:1];
        instr[FUNCT3_LSB +: 3] = funct3;
        instr[RS1_LSB +: 5]    = rs1;
        instr[RS2_LSB +: 5]    = rs2;
        instr[30:25]           = imm[10:5];
        instr[31]              = imm[12];
        if (!imm_fits(imm, 12)) err_code = ERR_RANGE;
        else if (imm[0])        err_code = ERR_ALIGN;
      end
      IMM_U: begin
        instr[RD_LSB +: 5]     = rd;
        instr[IMM_U_LSB +: 20] = imm[19:0];
        if (!imm_fits(imm, 19)) err_code = ERR_RANGE;
      end
      IMM_J: begin
        instr[RD_LSB +: 5] = rd;
        instr[19:12]       = imm[19:12];
        instr[20]          = imm[11];
        instr[30:21]       = imm[10:1];
        instr[31]          = imm[20];
        if (!imm_fits(imm, 20)) err_code = ERR_RANGE;
        else if (imm[0])        err_code = ERR_ALIGN;
      end
      default: err_code = ERR_IMMSRC;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder top: packs field tuples into RV32I words, tags them with
// a wrapping word address and buffers them in a two-entry FIFO.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  instr_encoder_if.slave    bus,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_base,
  output logic              err,
  output logic [1:0]        err_code
);

  logic [31:0]       packed_instr;
  err_code_t         packed_code;
  err_code_t         err_code_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       instr_q [2];
  logic [ADDR_W-1:0] addr_q  [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic              accept;
  logic              push;
  logic              pop;

  instr_encoder_imm_pack u_pack (
    .immsrc   (bus.in_immsrc),
    .imm      (bus.in_imm),
    .opcode   (bus.in_opcode),
    .rd       (bus.in_rd),
    .rs1      (bus.in_rs1),
    .rs2      (bus.in_rs2),
    .funct3   (bus.in_funct3),
    .instr    (packed_instr),
    .err_code (packed_code)
  );

  // in_ready depends only on the registered count, never on out_ready.
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_instr = instr_q[rd_ptr];
  assign bus.out_addr  = addr_q[rd_ptr];
  assign err_code      = err_code_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && (packed_code == ERR_NONE);
  assign pop    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_q[0] <= '0;
      instr_q[1] <= '0;
      addr_q[0]  <= '0;
      addr_q[1]  <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      wr_addr    <= '0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      if (push) begin
        instr_q[wr_ptr] <= packed_instr;
        addr_q[wr_ptr]  <= wr_addr;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // A load overrides the post-accept increment; the word itself already took the old address.
      if (addr_load)  wr_addr <= addr_base;
      else if (push)  wr_addr <= wr_addr + 1'b1;
      err <= accept && (packed_code != ERR_NONE);
      if (accept && (packed_code != ERR_NONE)) err_code_q <= packed_code;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios followed by random
// traffic, all compared against an arithmetic reference model and a queue.
module tb_instr_encoder;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       addr_load;
  logic [9:0] addr_base;
  logic       err;
  logic [1:0] err_code;

  int total = 0;
  int bad   = 0;

  logic [41:0] q [$];
  int          m_addr;
  logic        m_err;
  logic [1:0]  m_code;

  instr_encoder_if #(.ADDR_W(10)) bus ();

  instr_encoder #(.ADDR_W(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .addr_load (addr_load),
    .addr_base (addr_base),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] refCode(input logic [2:0] src, input logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (src)
      3'd0, 3'd1: return (v < -2048 || v > 2047) ? 2'd2 : 2'd0;
      3'd2: begin
        if (v < -4096 || v > 4095) return 2'd2;
        return imm[0] ? 2'd3 : 2'd0;
      end
      3'd3: begin
        if (v < -(64'sd1 << 20) || v >= (64'sd1 << 20)) return 2'd2;
        return imm[0] ? 2'd3 : 2'd0;
      end
      3'd4: return (v < -(64'sd1 << 19) || v >= (64'sd1 << 19)) ? 2'd2 : 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  function automatic logic [31:0] refInstr(input logic [2:0] src, input logic [31:0] imm,
                                           input logic [6:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [2:0] f3);
    logic [31:0] w;
    w = 32'(op);
    case (src)
      3'd0: w = w | ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7);
      3'd1: w = w | (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                  | (32'(f3) << 12) | ((imm & 32'h1F) << 7);
      3'd2: w = w | (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                  | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      3'd3: w = w | (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                  | (32'(rd) << 7);
      3'd4: w = w | ((imm & 32'hFFFFF) << 12) | (32'(rd) << 7);
      default: w = w;
    endcase
    return w;
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge, using the inputs currently driven.
  task automatic advance();
    bit         acc;
    bit         pop;
    bit         good;
    logic [1:0] c;
    acc  = bus.in_valid && (q.size() < 2);
    pop  = (q.size() > 0) && bus.out_ready;
    c    = refCode(bus.in_immsrc, bus.in_imm);
    good = acc && (c == 2'd0);
    if (!reset_n) begin
      q.delete();
      m_addr = 0;
      m_err  = 1'b0;
      m_code = 2'd0;
    end else begin
      if (pop) void'(q.pop_front());
      if (good)
        q.push_back({refInstr(bus.in_immsrc, bus.in_imm, bus.in_opcode, bus.in_rd,
                              bus.in_rs1, bus.in_rs2, bus.in_funct3), 10'(m_addr)});
      m_err = acc && (c != 2'd0);
      if (m_err) m_code = c;
      if (addr_load) m_addr = int'(addr_base);
      else if (good) m_addr = (m_addr + 1) % 1024;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput();
    checkEq("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    checkEq("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      checkEq("out_instr", bus.out_instr, q[0][41:10]);
      checkEq("out_addr", 32'(bus.out_addr), 32'(q[0][9:0]));
    end
    checkEq("err", 32'(err), 32'(m_err));
    checkEq("err_code", 32'(err_code), 32'(m_code));
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] src, input logic [31:0] imm,
                               input logic [6:0] op, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [2:0] f3);
    bus.in_valid  = v;
    bus.in_immsrc = src;
    bus.in_imm    = imm;
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    advance();
    checkOutput();
  endtask

  task automatic idleCycle();
    bus.in_valid = 1'b0;
    advance();
    checkOutput();
  endtask

  task automatic resetCycle();
    reset_n = 1'b0;
    idleCycle();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] imm;
    logic [2:0]  src;

    reset_n   = 1'b0;
    addr_load = 1'b0;
    addr_base = '0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_immsrc = '0;
    bus.in_imm    = '0;
    bus.in_opcode = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_funct3 = '0;
    m_addr = 0;
    m_err  = 1'b0;
    m_code = 2'd0;

    $display("[TB] reset");
    idleCycle();
    resetCycle();
    checkEq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkEq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkEq("rst_out_instr", bus.out_instr, 32'd0);
    checkEq("rst_out_addr", 32'(bus.out_addr), 32'd0);
    checkEq("rst_err", 32'(err), 32'd0);
    checkEq("rst_err_code", 32'(err_code), 32'd0);

    $display("[TB] directed encodings");
    applyStimulus(1'b1, 3'b000, 32'hFFFFF800, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0);
    checkEq("i_valid", 32'(bus.out_valid), 32'd1);
    checkEq("i_instr", bus.out_instr, 32'h80008113);
    checkEq("i_addr", 32'(bus.out_addr), 32'd0);
    checkEq("i_err", 32'(err), 32'd0);
    idleCycle();
    applyStimulus(1'b1, 3'b011, 32'h00000010, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0);
    checkEq("j_instr", bus.out_instr, 32'h010000EF);
    checkEq("j_addr", 32'(bus.out_addr), 32'd1);
    idleCycle();
    applyStimulus(1'b1, 3'b010, 32'h00000011, 7'h63, 5'd0, 5'd3, 5'd4, 3'd1);
    checkEq("b_err", 32'(err), 32'd1);
    checkEq("b_err_code", 32'(err_code), 32'd3);
    checkEq("b_no_word", 32'(bus.out_valid), 32'd0);
    idleCycle();
    checkEq("b_err_clear", 32'(err), 32'd0);
    checkEq("b_code_hold", 32'(err_code), 32'd3);
    applyStimulus(1'b1, 3'b100, 32'h00000015, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0);
    checkEq("u_instr", bus.out_instr, 32'h000153B7);
    checkEq("u_addr_unchanged", 32'(bus.out_addr), 32'd2);
    applyStimulus(1'b1, 3'b000, 32'h00000800, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
    checkEq("i_range_code", 32'(err_code), 32'd2);
    idleCycle();

    $display("[TB] backpressure");
    resetCycle();
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'b100, 32'h00000101, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0);
    checkEq("bp_ready1", 32'(bus.in_ready), 32'd1);
    applyStimulus(1'b1, 3'b100, 32'h00000102, 7'h37, 5'd2, 5'd0, 5'd0, 3'd0);
    checkEq("bp_ready2", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 3'b100, 32'h00000103, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0);
      checkEq("bp_head_instr", bus.out_instr, 32'h001010B7);
      checkEq("bp_head_addr", 32'(bus.out_addr), 32'd0);
    end
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 3'b100, 32'h00000103, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0);
    checkEq("bp_drain1", 32'(bus.out_addr), 32'd1);
    applyStimulus(1'b1, 3'b100, 32'h00000103, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0);
    checkEq("bp_drain2", 32'(bus.out_addr), 32'd2);
    idleCycle();

    $display("[TB] address load and wrap");
    resetCycle();
    addr_load = 1'b1;
    addr_base = 10'h3FF;
    applyStimulus(1'b1, 3'b000, 32'h00000005, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0);
    checkEq("ld_same_cycle_addr", 32'(bus.out_addr), 32'h000);
    addr_load = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'h00000006, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0);
    checkEq("ld_base_addr", 32'(bus.out_addr), 32'h3FF);
    applyStimulus(1'b1, 3'b000, 32'h00000007, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0);
    checkEq("ld_wrap_addr", 32'(bus.out_addr), 32'h000);
    idleCycle();

    $display("[TB] reset while full");
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'h00000001, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
    applyStimulus(1'b1, 3'b000, 32'h00000002, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
    reset_n = 1'b0;
    applyStimulus(1'b1, 3'b111, 32'h0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
    reset_n = 1'b1;
    checkEq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkEq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    checkEq("midrst_err", 32'(err), 32'd0);
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 3'b101, 32'h0, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
    checkEq("bad_src_err", 32'(err), 32'd1);
    checkEq("bad_src_code", 32'(err_code), 32'd1);

    $display("[TB] random traffic");
    for (int n = 0; n < 500; n++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      addr_load     = ($urandom_range(0, 15) == 0);
      addr_base     = 10'($urandom);
      src = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      r = $urandom;
      case ($urandom_range(0, 3))
        0:       imm = r;
        1:       imm = {{20{r[11]}}, r[11:0]};
        2:       imm = {{19{r[12]}}, r[12:1], ($urandom_range(0, 3) == 0)};
        default: imm = {{11{r[20]}}, r[20:1], ($urandom_range(0, 3) == 0)};
      endcase
      applyStimulus(($urandom_range(0, 3) != 0), src, imm, 7'($urandom), 5'($urandom),
                    5'($urandom), 5'($urandom), 3'($urandom));
    end
    bus.out_ready = 1'b1;
    addr_load     = 1'b0;
    for (int n = 0; n < 3; n++) idleCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
